// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Sole owner of the register file write port. After reset it walks the
//   write port through registers 0..31 writing zero, then shares the port
//   between two writeback requesters (ALU result on req0, load result on
//   req1) with valid/ready handshakes and round-robin arbitration.
//
// Ports:
//   i_clock                 system clock, rising-edge active
//   i_reset                 synchronous, active-high reset
//   i_req0_valid/reg/data   requester 0 write request
//   o_req0_ready            requester 0 accepted this cycle
//   i_req1_valid/reg/data   requester 1 write request
//   o_req1_ready            requester 1 accepted this cycle
//   o_init_done             clear sequence finished, requests being served
//   o_WriteReg              to registerfile WriteReg
//   o_WriteData             to registerfile WriteData
//   o_RegWrite              to registerfile RegWrite
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int W = 32
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_req0_valid,
    input  logic [4:0]   i_req0_reg,
    input  logic [W-1:0] i_req0_data,
    output logic         o_req0_ready,
    input  logic         i_req1_valid,
    input  logic [4:0]   i_req1_reg,
    input  logic [W-1:0] i_req1_data,
    output logic         o_req1_ready,
    output logic         o_init_done,
    output logic [4:0]   o_WriteReg,
    output logic [W-1:0] o_WriteData,
    output logic         o_RegWrite
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_nextState;
    logic [4:0]   r_count;
    logic         r_last;
    logic         r_regWrite;
    logic [4:0]   r_writeReg;
    logic [W-1:0] r_writeData;
    logic         w_run;
    logic         w_grant0;
    logic         w_grant1;

    // Grant is purely a function of the valids, the state, the round-robin
    // pointer and reset, so ready never depends on request data. When both
    // requesters are valid, the one that did not win last time is served.
    always_comb begin
        w_run    = (r_state == RUN) && !i_reset;
        w_grant0 = w_run && i_req0_valid && (!i_req1_valid || r_last);
        w_grant1 = w_run && i_req1_valid && (!i_req0_valid || !r_last);
    end

    // Next-state logic: leave CLEAR once register 31 has been written.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            CLEAR:   if (r_count == 5'd31) w_nextState = RUN;
            RUN:     w_nextState = RUN;
            default: w_nextState = CLEAR;
        endcase
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Clear counter steps through 0..31 and parks at 31 rather than wrapping,
    // so it is already stable when the state flips to RUN.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= 5'd0;
        end else if ((r_state == CLEAR) && (r_count != 5'd31)) begin
            r_count <= r_count + 5'd1;
        end
    end

    // Output stage and round-robin pointer. The stage only changes in RUN:
    // an accepted request is registered for one cycle, while an idle edge
    // drops RegWrite but keeps the last address/data visible. Writes aimed
    // at x0 complete the handshake but never raise RegWrite. The pointer
    // resets to 1 so req0 wins the first contended grant.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last      <= 1'b1;
            r_regWrite  <= 1'b0;
            r_writeReg  <= 5'd0;
            r_writeData <= '0;
        end else if (r_state == RUN) begin
            if (w_grant0) begin
                r_writeReg  <= i_req0_reg;
                r_writeData <= i_req0_data;
                r_regWrite  <= (i_req0_reg != 5'd0);
                r_last      <= 1'b0;
            end else if (w_grant1) begin
                r_writeReg  <= i_req1_reg;
                r_writeData <= i_req1_data;
                r_regWrite  <= (i_req1_reg != 5'd0);
                r_last      <= 1'b1;
            end else begin
                r_regWrite  <= 1'b0;
            end
        end
    end

    // Port muxing: during CLEAR the counter drives the port directly with a
    // zero write each cycle; in RUN the registered stage drives it. Reset
    // suppresses every strobe so nothing staged can leak onto the port.
    always_comb begin
        o_req0_ready = w_grant0;
        o_req1_ready = w_grant1;
        o_init_done  = w_run;
        o_WriteReg   = r_writeReg;
        o_WriteData  = r_writeData;
        o_RegWrite   = 1'b0;
        if (r_state == CLEAR) begin
            o_WriteReg  = r_count;
            o_WriteData = '0;
            o_RegWrite  = !i_reset;
        end else begin
            o_RegWrite  = r_regWrite && !i_reset;
        end
    end

endmodule
